// File: rtl/apuf_eval_ctrl.sv
// -----------------------------------------------------------------------------
// apuf_eval_ctrl
//
// Sequencer for one arbiter-PUF evaluation. A challenge accepted over a
// valid/ready handshake is driven onto the switch chain select inputs. The
// race edge on inT/inB then fires NREP times. On each firing the synchronized
// arbiter output is sampled. The block returns a majority-voted response bit,
// a stability flag and the raw ones count.
//
// Parameters:
//   CW         challenge width (switch chain stage count)
//   SETTLE_CYC cycles with inT/inB low before each firing (>= 1)
//   RACE_CYC   cycles with inT/inB high per firing (>= 3)
//   NREP       firings per evaluation (odd, >= 1)
//   OW         width of the ones count
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   chal_valid/chal_ready     challenge handshake (ready only in IDLE)
//   chal  [CW-1:0]            challenge bits
//   c     [CW-1:0]            registered select bits to the switch chain
//   inT, inB                  registered race inputs, always equal
//   arb_out                   arbiter latch output (asynchronous)
//   resp_valid/resp_ready     response handshake
//   resp, resp_stable         majority vote, all-samples-agree flag
//   ones_cnt [OW-1:0]         number of samples equal to 1
// -----------------------------------------------------------------------------
module apuf_eval_ctrl #(
  parameter int CW         = 16,
  parameter int SETTLE_CYC = 8,
  parameter int RACE_CYC   = 16,
  parameter int NREP       = 5,
  parameter int OW         = $clog2(NREP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          chal_valid,
  output logic          chal_ready,
  input  logic [CW-1:0] chal,
  output logic [CW-1:0] c,
  output logic          inT,
  output logic          inB,
  input  logic          arb_out,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp,
  output logic          resp_stable,
  output logic [OW-1:0] ones_cnt
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_FIRE  = 3'd2;
  localparam logic [2:0] S_RELAX = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CNT_MAX = (SETTLE_CYC > RACE_CYC) ? SETTLE_CYC : RACE_CYC;
  localparam int CNTW    = $clog2(CNT_MAX + 1);

  // Down-counter reload values: a phase of N cycles counts N-1 .. 0.
  localparam logic [CNTW-1:0] SETTLE_LD = CNTW'(SETTLE_CYC - 1);
  localparam logic [CNTW-1:0] RACE_LD   = CNTW'(RACE_CYC - 1);
  localparam logic [OW-1:0]   NREP_C    = OW'(NREP);
  localparam logic [OW-1:0]   HALF_C    = OW'(NREP / 2);

  logic [2:0]      state_q,       state_d;
  logic [CW-1:0]   c_q,           c_d;
  logic            fire_q,        fire_d;
  logic [CNTW-1:0] cnt_q,         cnt_d;
  logic [OW-1:0]   rep_q,         rep_d;
  logic [OW-1:0]   ones_q,        ones_d;
  logic            resp_valid_q,  resp_valid_d;
  logic            resp_q,        resp_d;
  logic            stable_q,      stable_d;
  logic            sync1_q,       sync2_q;
  logic [OW-1:0]   rep_inc;

  assign rep_inc = rep_q + OW'(1);

  always_comb begin
    // NOTE: every variable gets its hold value first, so no path through the
    // case statement leaves one unassigned and no latch is inferred.
    state_d      = state_q;
    c_d          = c_q;
    fire_d       = fire_q;
    cnt_d        = cnt_q;
    rep_d        = rep_q;
    ones_d       = ones_q;
    resp_valid_d = resp_valid_q;
    resp_d       = resp_q;
    stable_d     = stable_q;

    case (state_q)
      S_IDLE: begin
        if (chal_valid) begin
          c_d     = chal;
          ones_d  = '0;
          rep_d   = '0;
          cnt_d   = SETTLE_LD;
          state_d = S_SETUP;
        end
      end

      S_SETUP: begin
        if (cnt_q == '0) begin
          // The race output is registered, so it is raised on the edge that
          // enters FIRE and is high for exactly the FIRE cycles.
          fire_d  = 1'b1;
          cnt_d   = RACE_LD;
          state_d = S_FIRE;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_FIRE: begin
        if (cnt_q == '0) begin
          // Last race cycle: the arbiter has had RACE_CYC-1 cycles to latch
          // and cross the synchronizer, so the second flop is safe to use.
          ones_d  = ones_q + OW'(sync2_q);
          fire_d  = 1'b0;
          cnt_d   = SETTLE_LD;
          state_d = S_RELAX;
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_RELAX: begin
        if (cnt_q == '0) begin
          rep_d = rep_inc;
          if (rep_inc == NREP_C) begin
            // ones_q already holds the final sample, so the verdict can be
            // registered together with resp_valid.
            resp_valid_d = 1'b1;
            resp_d       = (ones_q > HALF_C);
            stable_d     = (ones_q == '0) || (ones_q == NREP_C);
            state_d      = S_DONE;
          end else begin
            fire_d  = 1'b1;
            cnt_d   = RACE_LD;
            state_d = S_FIRE;
          end
        end else begin
          cnt_d = cnt_q - CNTW'(1);
        end
      end

      S_DONE: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        fire_d       = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      c_q          <= '0;
      fire_q       <= 1'b0;
      cnt_q        <= '0;
      rep_q        <= '0;
      ones_q       <= '0;
      resp_valid_q <= 1'b0;
      resp_q       <= 1'b0;
      stable_q     <= 1'b0;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop take its pre-edge
      // inputs, which is what lets sync1_q -> sync2_q form a real two-stage
      // synchronizer instead of collapsing into one flop.
      state_q      <= state_d;
      c_q          <= c_d;
      fire_q       <= fire_d;
      cnt_q        <= cnt_d;
      rep_q        <= rep_d;
      ones_q       <= ones_d;
      resp_valid_q <= resp_valid_d;
      resp_q       <= resp_d;
      stable_q     <= stable_d;
      sync1_q      <= arb_out;
      sync2_q      <= sync1_q;
    end
  end

  assign chal_ready  = (state_q == S_IDLE);
  assign c           = c_q;
  // Both race inputs come from the same flop so they can never differ.
  assign inT         = fire_q;
  assign inB         = fire_q;
  assign resp_valid  = resp_valid_q;
  assign resp        = resp_q;
  assign resp_stable = stable_q;
  assign ones_cnt    = ones_q;

endmodule
